// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller for the rv32 5-stage core.
// Produces pipeline-register enables/flushes for load-use hazards, taken
// redirects and data-memory wait states, EX-stage forwarding selects, a
// sticky dmem-timeout fault and saturating perf counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RUN     | normal flow, no outstanding dmem wait
// WAIT    | dmem wait in progress, wait_cnt counts consecutive wait cycles
// FAULT   | dmem timed out; pipeline frozen until reset
module pipe_hazard_ctl #(
  parameter int MEM_TO = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_RegWEn,
  input  logic             idex_is_load,
  input  logic             ex_pc_sel,
  input  logic [4:0]       exm_rd,
  input  logic             exm_RegWEn,
  input  logic             exm_is_load,
  input  logic [4:0]       mwb_rd,
  input  logic             mwb_RegWEn,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int WW = $clog2(MEM_TO) + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TO - 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;

  logic [6:0] opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       ldu;
  logic       frz;
  logic       halted;
  logic       br_act;
  logic       ldu_act;
  logic       unused_instr;

  assign opcode = id_instr[6:0];
  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];
  // Fields outside opcode/rs1/rs2 do not influence hazard detection.
  assign unused_instr = ^{id_instr[31:25], id_instr[14:7]};

  // LUI, AUIPC and JAL carry no rs1; only branches, stores and R-type read rs2.
  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111: rs1_used = 1'b0;
      default:                            rs1_used = 1'b1;
    endcase
    case (opcode)
      7'b1100011, 7'b0100011, 7'b0110011: rs2_used = 1'b1;
      default:                            rs2_used = 1'b0;
    endcase
  end

  assign ldu = idex_is_load & idex_RegWEn & (idex_rd != 5'd0) &
               ((rs1_used & (id_rs1 == idex_rd)) | (rs2_used & (id_rs2 == idex_rd)));
  assign frz = dmem_req & ~dmem_ready;

  assign halted  = rst | (state == ST_FAULT);
  assign br_act  = ~halted & ~frz & ex_pc_sel;
  assign ldu_act = ~halted & ~frz & ~ex_pc_sel & ldu;

  // Enable/flush priority: halt, then dmem freeze, then redirect, then load-use bubble.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (halted) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (frz) begin
      // Frozen EX holds ex_pc_sel, so the redirect lands on the release cycle.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_pc_sel) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ldu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] e_rd, input logic e_we,
                                         input logic e_ld,
                                         input logic [4:0] w_rd, input logic w_we);
    if (e_we && (e_rd != 5'd0) && (e_rd == rs) && !e_ld) return 2'b01;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))      return 2'b10;
    else                                                  return 2'b00;
  endfunction

  // Forwarding selects, independent of FSM state; a load in MEM has no data yet.
  always_comb begin
    fwd_a = fwd_sel(idex_rs1, exm_rd, exm_RegWEn, exm_is_load, mwb_rd, mwb_RegWEn);
    fwd_b = fwd_sel(idex_rs2, exm_rd, exm_RegWEn, exm_is_load, mwb_rd, mwb_RegWEn);
  end

  // Dmem timeout FSM with sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (frz) begin
            state    <= ST_WAIT;
            wait_cnt <= WW'(1);
          end
        end
        ST_WAIT: begin
          if (!frz) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= ST_FAULT;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_FAULT: mem_err <= 1'b1;
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating perf counters for load-use bubbles and taken redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ldu_act && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_act && (flush_cnt != {CNT_W{1'b1}}))  flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
